// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: turns hazard, memory-wait, divider and
// redirect events into per-stage hold/bubble controls, with a memory watchdog and stall counter.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 1024,
    parameter int CNT_W       = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_rs1_used,
    input  logic             dec_rs2_used,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             ex_div_start,
    input  logic             div_done,
    input  logic             mem_req_valid,
    input  logic             mem_ready,
    input  logic             trap_redirect,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             bubble_D,
    output logic             bubble_E,
    output logic             bubble_M,
    output logic             bubble_W,
    output logic             div_kill,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DIV_WAIT} state_t;

    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_use;
    logic              lower_en;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((dec_rs1_used && (dec_rs1 == ex_rd)) ||
                       (dec_rs2_used && (dec_rs2 == ex_rd)));

    assign wd_inc = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);

    always_comb begin
        stall_F  = 1'b0;
        stall_D  = 1'b0;
        stall_E  = 1'b0;
        stall_M  = 1'b0;
        bubble_D = 1'b0;
        bubble_E = 1'b0;
        bubble_M = 1'b0;
        bubble_W = 1'b0;
        div_kill = 1'b0;
        lower_en = 1'b0;
        state_d  = state_q;
        wd_d     = wd_q;
        err_d    = err_q;

        if (rst) begin
            bubble_D = 1'b1;
            bubble_E = 1'b1;
            bubble_M = 1'b1;
            bubble_W = 1'b1;
            state_d  = RUN;
            wd_d     = '0;
            err_d    = 1'b0;
        end else if (trap_redirect) begin
            bubble_D = 1'b1;
            bubble_E = 1'b1;
            bubble_M = 1'b1;
            bubble_W = 1'b1;
            div_kill = (state_q == DIV_WAIT);
            state_d  = RUN;
            wd_d     = '0;
        end else begin
            case (state_q)
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        stall_F  = 1'b1;
                        stall_D  = 1'b1;
                        stall_E  = 1'b1;
                        stall_M  = 1'b1;
                        bubble_W = 1'b1;
                        wd_d     = wd_inc;
                        if (wd_inc == WD_MAX) err_d = 1'b1;
                    end else begin
                        // Release cycle behaves like RUN for the lower-priority sources
                        state_d  = RUN;
                        wd_d     = '0;
                        lower_en = 1'b1;
                    end
                end
                DIV_WAIT: begin
                    if (!div_done) begin
                        stall_F  = 1'b1;
                        stall_D  = 1'b1;
                        stall_E  = 1'b1;
                        bubble_M = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    if (mem_req_valid && !mem_ready) begin
                        stall_F  = 1'b1;
                        stall_D  = 1'b1;
                        stall_E  = 1'b1;
                        stall_M  = 1'b1;
                        bubble_W = 1'b1;
                        state_d  = MEM_WAIT;
                    end else begin
                        lower_en = 1'b1;
                    end
                end
            endcase

            if (lower_en) begin
                if (ex_div_start) begin
                    // A divide finishing in its issue cycle needs no wait
                    if (!div_done) begin
                        stall_F  = 1'b1;
                        stall_D  = 1'b1;
                        stall_E  = 1'b1;
                        bubble_M = 1'b1;
                        state_d  = DIV_WAIT;
                    end
                end else if (ex_redirect) begin
                    bubble_D = 1'b1;
                    bubble_E = 1'b1;
                end else if (load_use) begin
                    stall_F  = 1'b1;
                    stall_D  = 1'b1;
                    bubble_E = 1'b1;
                end
            end
        end

        cnt_d = rst ? '0 : (stall_F ? cnt_q + CNT_W'(1) : cnt_q);
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        wd_q    <= wd_d;
        err_q   <= err_d;
        cnt_q   <= cnt_d;
    end

    assign mem_timeout_err = err_q;
    assign stall_cycles    = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic, checked against
// a priority-rule reference model of the sequencer.
module tb_pipe_hazard_ctrl;

    localparam int T  = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] dec_rs1, dec_rs2, ex_rd;
    logic dec_rs1_used, dec_rs2_used, ex_valid, ex_is_load, ex_redirect;
    logic ex_div_start, div_done, mem_req_valid, mem_ready, trap_redirect;
    logic stall_F, stall_D, stall_E, stall_M;
    logic bubble_D, bubble_E, bubble_M, bubble_W, div_kill, mem_timeout_err;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .ex_div_start(ex_div_start), .div_done(div_done),
        .mem_req_valid(mem_req_valid), .mem_ready(mem_ready), .trap_redirect(trap_redirect),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .bubble_D(bubble_D), .bubble_E(bubble_E), .bubble_M(bubble_M), .bubble_W(bubble_W),
        .div_kill(div_kill), .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: which long-latency event is outstanding, plus counters
    bit m_mem_busy, m_div_busy, m_err;
    int m_wait_cnt, m_stalls;

    logic [8:0]    exp_o, act_o;
    logic          exp_err, act_err;
    logic [CW-1:0] exp_cnt, act_cnt;

    // Output vector order: {stall F,D,E,M, bubble D,E,M,W, div_kill}
    localparam logic [8:0] O_NONE  = 9'b0000_0000_0;
    localparam logic [8:0] O_FLUSH = 9'b0000_1111_0;
    localparam logic [8:0] O_MEM   = 9'b1111_0001_0;
    localparam logic [8:0] O_DIV   = 9'b1110_0010_0;
    localparam logic [8:0] O_REDIR = 9'b0000_1100_0;
    localparam logic [8:0] O_LU    = 9'b1100_0100_0;

    function automatic bit hazard();
        if (!(ex_valid && ex_is_load) || ex_rd == 0) return 0;
        return (dec_rs1_used && dec_rs1 == ex_rd) || (dec_rs2_used && dec_rs2 == ex_rd);
    endfunction

    function automatic logic [8:0] lower_out();
        if (ex_div_start) return div_done ? O_NONE : O_DIV;
        if (ex_redirect)  return O_REDIR;
        if (hazard())     return O_LU;
        return O_NONE;
    endfunction

    function automatic logic [8:0] model_out();
        if (rst)           return O_FLUSH;
        if (trap_redirect) return O_FLUSH | {8'b0, m_div_busy};
        if (m_mem_busy)    return mem_ready ? lower_out() : O_MEM;
        if (m_div_busy)    return div_done ? O_NONE : O_DIV;
        if (mem_req_valid && !mem_ready) return O_MEM;
        return lower_out();
    endfunction

    task automatic idle();
        rst = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_redirect = 0; ex_div_start = 0;
        div_done = 0; mem_req_valid = 0; mem_ready = 0; trap_redirect = 0;
    endtask

    task automatic eval();
        #1;
        exp_o   = model_out();
        exp_err = m_err;
        exp_cnt = CW'(m_stalls);
        act_o   = {stall_F, stall_D, stall_E, stall_M, bubble_D, bubble_E, bubble_M, bubble_W, div_kill};
        act_err = mem_timeout_err;
        act_cnt = stall_cycles;
    endtask

    task automatic commit();
        if (rst) begin
            m_mem_busy = 0; m_div_busy = 0; m_err = 0; m_wait_cnt = 0; m_stalls = 0;
        end else begin
            if (trap_redirect) begin
                m_mem_busy = 0; m_div_busy = 0; m_wait_cnt = 0;
            end else if (m_mem_busy) begin
                if (!mem_ready) begin
                    m_wait_cnt = (m_wait_cnt + 1 > T - 1) ? T - 1 : m_wait_cnt + 1;
                    if (m_wait_cnt == T - 1) m_err = 1;
                end else begin
                    m_mem_busy = 0; m_wait_cnt = 0;
                    if (ex_div_start && !div_done) m_div_busy = 1;
                end
            end else if (m_div_busy) begin
                if (div_done) m_div_busy = 0;
            end else if (mem_req_valid && !mem_ready) begin
                m_mem_busy = 1;
            end else if (ex_div_start && !div_done) begin
                m_div_busy = 1;
            end
            m_stalls = (m_stalls + int'(exp_o[8])) % (1 << CW);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            idle(); rst = 1;
            mem_req_valid = 1; ex_div_start = c[0]; ex_redirect = 1;
            eval();
            if ({act_o, act_err, act_cnt} !== {exp_o, exp_err, exp_cnt}) begin
                fails++;
                $display("FAIL reset c%0d: got o=%b err=%b cnt=%0d want o=%b err=%b cnt=%0d",
                         c, act_o, act_err, act_cnt, exp_o, exp_err, exp_cnt);
            end
            checks++;
            if (c == 2) begin
                if ({act_o, act_err, act_cnt} !== {O_FLUSH, 1'b0, {CW{1'b0}}}) begin
                    fails++;
                    $display("FAIL reset_const: got o=%b err=%b cnt=%0d want o=%b err=0 cnt=0",
                             act_o, act_err, act_cnt, O_FLUSH);
                end
                checks++;
            end
            commit();
        end
    endtask

    task automatic test_load_use(input bit use_x0);
        logic [CW-1:0] cnt0;
        cnt0 = stall_cycles;
        for (int c = 0; c < 3; c++) begin
            idle();
            if (c == 0) begin
                ex_valid = 1; ex_is_load = 1; ex_rd = use_x0 ? 5'd0 : 5'd5;
                dec_rs2 = use_x0 ? 5'd0 : 5'd5; dec_rs2_used = 1; dec_rs1 = 5'd3; dec_rs1_used = 1;
            end
            eval();
            if ({act_o, act_err, act_cnt} !== {exp_o, exp_err, exp_cnt}) begin
                fails++;
                $display("FAIL load_use(x0=%0d) c%0d: got o=%b err=%b cnt=%0d want o=%b err=%b cnt=%0d",
                         use_x0, c, act_o, act_err, act_cnt, exp_o, exp_err, exp_cnt);
            end
            checks++;
            if (c == 0 && act_o !== (use_x0 ? O_NONE : O_LU)) begin
                fails++;
                $display("FAIL load_use_out(x0=%0d): got %b want %b", use_x0, act_o, use_x0 ? O_NONE : O_LU);
            end
            if (c == 0) checks++;
            if (c == 1 && act_cnt !== cnt0 + CW'(use_x0 ? 0 : 1)) begin
                fails++;
                $display("FAIL load_use_cnt(x0=%0d): got %0d want %0d", use_x0, act_cnt, cnt0 + CW'(use_x0 ? 0 : 1));
            end
            if (c == 1) checks++;
            commit();
        end
    endtask

    task automatic test_mem_wait();
        for (int c = 0; c < 5; c++) begin
            idle();
            if (c < 4) begin mem_req_valid = 1; mem_ready = (c == 3); end
            eval();
            if ({act_o, act_err, act_cnt} !== {exp_o, exp_err, exp_cnt}) begin
                fails++;
                $display("FAIL mem_wait c%0d: got o=%b err=%b cnt=%0d want o=%b err=%b cnt=%0d",
                         c, act_o, act_err, act_cnt, exp_o, exp_err, exp_cnt);
            end
            checks++;
            if (c <= 3 && act_o !== (c < 3 ? O_MEM : O_NONE)) begin
                fails++;
                $display("FAIL mem_wait_out c%0d: got %b want %b", c, act_o, c < 3 ? O_MEM : O_NONE);
            end
            if (c <= 3) checks++;
            commit();
        end
    endtask

    task automatic test_div_trap();
        for (int c = 0; c < 4; c++) begin
            idle();
            ex_div_start = (c == 0);
            trap_redirect = (c == 2);
            eval();
            if ({act_o, act_err, act_cnt} !== {exp_o, exp_err, exp_cnt}) begin
                fails++;
                $display("FAIL div_trap c%0d: got o=%b err=%b cnt=%0d want o=%b err=%b cnt=%0d",
                         c, act_o, act_err, act_cnt, exp_o, exp_err, exp_cnt);
            end
            checks++;
            if (c == 2 && act_o !== 9'b0000_1111_1) begin
                fails++;
                $display("FAIL div_kill_out: got %b want 000011111", act_o);
            end
            if (c == 2) checks++;
            commit();
        end
    endtask

    task automatic test_timeout();
        for (int c = 0; c < 10; c++) begin
            idle();
            if (c < 7) begin mem_req_valid = 1; mem_ready = (c == 6); end
            rst = (c == 8);
            eval();
            if ({act_o, act_err, act_cnt} !== {exp_o, exp_err, exp_cnt}) begin
                fails++;
                $display("FAIL timeout c%0d: got o=%b err=%b cnt=%0d want o=%b err=%b cnt=%0d",
                         c, act_o, act_err, act_cnt, exp_o, exp_err, exp_cnt);
            end
            checks++;
            if (act_err !== (c >= 4 && c <= 8)) begin
                fails++;
                $display("FAIL timeout_err c%0d: got %b want %b", c, act_err, (c >= 4 && c <= 8));
            end
            checks++;
            commit();
        end
    endtask

    task automatic test_priority();
        for (int c = 0; c < 4; c++) begin
            idle();
            ex_valid = 1; ex_is_load = 1; ex_rd = 5'd7; dec_rs1 = 5'd7; dec_rs1_used = 1;
            ex_redirect = (c == 0);
            if (c == 1) begin ex_div_start = 1; div_done = 1; end
            if (c == 2) begin mem_req_valid = 1; mem_ready = 1; end
            if (c == 3) ex_valid = 0;
            eval();
            if ({act_o, act_err, act_cnt} !== {exp_o, exp_err, exp_cnt}) begin
                fails++;
                $display("FAIL priority c%0d: got o=%b err=%b cnt=%0d want o=%b err=%b cnt=%0d",
                         c, act_o, act_err, act_cnt, exp_o, exp_err, exp_cnt);
            end
            checks++;
            if (c < 2 && act_o !== (c == 0 ? O_REDIR : O_NONE)) begin
                fails++;
                $display("FAIL priority_out c%0d: got %b want %b", c, act_o, c == 0 ? O_REDIR : O_NONE);
            end
            if (c < 2) checks++;
            commit();
        end
    endtask

    task automatic test_cnt_wrap();
        for (int c = 0; c < 262; c++) begin
            idle();
            ex_div_start = (c == 0);
            div_done = (c == 260);
            eval();
            if ({act_o, act_err, act_cnt} !== {exp_o, exp_err, exp_cnt}) begin
                fails++;
                $display("FAIL cnt_wrap c%0d: got o=%b err=%b cnt=%0d want o=%b err=%b cnt=%0d",
                         c, act_o, act_err, act_cnt, exp_o, exp_err, exp_cnt);
            end
            checks++;
            commit();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst           = ($urandom_range(99) < 1);
            dec_rs1       = 5'($urandom_range(3));
            dec_rs2       = 5'($urandom_range(3));
            dec_rs1_used  = 1'($urandom_range(1));
            dec_rs2_used  = 1'($urandom_range(1));
            ex_valid      = ($urandom_range(99) < 80);
            ex_is_load    = ($urandom_range(99) < 40);
            ex_rd         = 5'($urandom_range(3));
            ex_redirect   = ($urandom_range(99) < 10);
            ex_div_start  = ($urandom_range(99) < 6);
            div_done      = ($urandom_range(99) < 20);
            mem_req_valid = ($urandom_range(99) < 30);
            mem_ready     = ($urandom_range(99) < 55);
            trap_redirect = ($urandom_range(99) < 3);
            eval();
            if ({act_o, act_err, act_cnt} !== {exp_o, exp_err, exp_cnt}) begin
                fails++;
                $display("FAIL random c%0d: got o=%b err=%b cnt=%0d want o=%b err=%b cnt=%0d",
                         c, act_o, act_err, act_cnt, exp_o, exp_err, exp_cnt);
            end
            checks++;
            commit();
        end
    endtask

    initial begin
        idle();
        rst = 1;
        m_mem_busy = 0; m_div_busy = 0; m_err = 0; m_wait_cnt = 0; m_stalls = 0;
        @(negedge clk);
        test_reset();
        test_load_use(1'b0);
        test_load_use(1'b1);
        test_mem_wait();
        test_div_trap();
        test_timeout();
        test_priority();
        test_cnt_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
